// File: rtl/sc_button_conditioner_if.sv
// Button bundle between the Frogger board pins and the point state machine.
// master drives the raw pins; slave is the conditioner.
interface sc_button_conditioner_if;
  logic [4:0] SC_BUTTONCOND_raw_InLow;
  logic [4:0] SC_BUTTONCOND_level_OutLow;
  logic [4:0] SC_BUTTONCOND_press_Out;

  modport master (
    output SC_BUTTONCOND_raw_InLow,
    input  SC_BUTTONCOND_level_OutLow,
    input  SC_BUTTONCOND_press_Out
  );

  modport slave (
    input  SC_BUTTONCOND_raw_InLow,
    output SC_BUTTONCOND_level_OutLow,
    output SC_BUTTONCOND_press_Out
  );
endinterface

// File: rtl/sc_button_conditioner.sv
// Five-channel button conditioner: 2-flop sync, debounce FSM and press strobe per channel.
// Optional auto-repeat on held direction buttons via macro SC_BUTTONCOND_AUTOREPEAT_EN.
//
// state        | meaning
// RELEASED     | button up, level=1
// PRESS_WAIT   | low seen, counting stable low samples
// PRESSED      | button down, level=0 (counts hold time when auto-repeat is built)
// RELEASE_WAIT | high seen, counting stable high samples
// GAP          | auto-repeat only: forced level=1 for two cycles while still held
module sc_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 15000000,
  parameter int CNT_W           = 24
) (
  input logic                    SC_BUTTONCOND_CLOCK_50,
  input logic                    SC_BUTTONCOND_RESET_InLow,
  sc_button_conditioner_if.slave btnIf
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef SC_BUTTONCOND_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  typedef enum logic [2:0] {
    RELEASED     = 3'd0,
    PRESS_WAIT   = 3'd1,
    PRESSED      = 3'd2,
    RELEASE_WAIT = 3'd3,
    GAP          = 3'd4
  } chanStateT;
`else
  typedef enum logic [2:0] {
    RELEASED     = 3'd0,
    PRESS_WAIT   = 3'd1,
    PRESSED      = 3'd2,
    RELEASE_WAIT = 3'd3
  } chanStateT;
`endif

  logic [4:0] sync1, sync2;
  logic [4:0] levelVec, pressVec;

  always_ff @(posedge SC_BUTTONCOND_CLOCK_50 or negedge SC_BUTTONCOND_RESET_InLow) begin
    if (!SC_BUTTONCOND_RESET_InLow) begin
      sync1 <= 5'b11111;
      sync2 <= 5'b11111;
    end else begin
      sync1 <= btnIf.SC_BUTTONCOND_raw_InLow;
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < 5; g++) begin : gChan
    // start button (channel 4) must never auto-repeat
    localparam bit CAN_REPEAT = (g != 4);

    chanStateT        state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic             levelQ, levelNext;
    logic             pressQ, pressNext;

    always_ff @(posedge SC_BUTTONCOND_CLOCK_50 or negedge SC_BUTTONCOND_RESET_InLow) begin
      if (!SC_BUTTONCOND_RESET_InLow) begin
        state  <= RELEASED;
        cnt    <= '0;
        levelQ <= 1'b1;
        pressQ <= 1'b0;
      end else begin
        state  <= stateNext;
        cnt    <= cntNext;
        levelQ <= levelNext;
        pressQ <= pressNext;
      end
    end

    always_comb begin
      stateNext = state;
      cntNext   = cnt;
      levelNext = levelQ;
      pressNext = 1'b0;
      case (state)
        RELEASED: begin
          levelNext = 1'b1;
          if (!sync2[g]) begin
            stateNext = PRESS_WAIT;
            cntNext   = CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (sync2[g]) begin
            stateNext = RELEASED;
            cntNext   = '0;
          end else if (cnt == DEB_LAST) begin
            stateNext = PRESSED;
            cntNext   = '0;
            levelNext = 1'b0;
            pressNext = 1'b1;
          end else begin
            cntNext = cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (sync2[g]) begin
            stateNext = RELEASE_WAIT;
            cntNext   = CNT_ONE;
          end
`ifdef SC_BUTTONCOND_AUTOREPEAT_EN
          else if (CAN_REPEAT && cnt == REP_LAST) begin
            stateNext = GAP;
            cntNext   = '0;
            levelNext = 1'b1;
          end else if (CAN_REPEAT) begin
            cntNext = cnt + CNT_ONE;
          end
`endif
        end
        RELEASE_WAIT: begin
          // level is forced low on bounce-back so a release begun from GAP re-presses cleanly
          if (!sync2[g]) begin
            stateNext = PRESSED;
            cntNext   = '0;
            levelNext = 1'b0;
          end else if (cnt == DEB_LAST) begin
            stateNext = RELEASED;
            cntNext   = '0;
            levelNext = 1'b1;
          end else begin
            cntNext = cnt + CNT_ONE;
          end
        end
`ifdef SC_BUTTONCOND_AUTOREPEAT_EN
        GAP: begin
          if (sync2[g]) begin
            stateNext = RELEASE_WAIT;
            cntNext   = CNT_ONE;
          end else if (cnt == CNT_ONE) begin
            stateNext = PRESSED;
            cntNext   = '0;
            levelNext = 1'b0;
            pressNext = 1'b1;
          end else begin
            cntNext = cnt + CNT_ONE;
          end
        end
`endif
        default: begin
          stateNext = RELEASED;
          cntNext   = '0;
          levelNext = 1'b1;
        end
      endcase
    end

    assign levelVec[g] = levelQ;
    assign pressVec[g] = pressQ;
  end

  assign btnIf.SC_BUTTONCOND_level_OutLow = levelVec;
  assign btnIf.SC_BUTTONCOND_press_Out    = pressVec;

endmodule

// File: tb/tb_sc_button_conditioner.sv
// Directed bench for sc_button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10.
// Auto-repeat expectations are used when SC_BUTTONCOND_AUTOREPEAT_EN is defined.
module tb_sc_button_conditioner;

  logic       clk;
  logic       rstN;
  logic [4:0] rawDrv;
  logic [4:0] levelObs, pressObs;
  int         testsRun;
  int         testsFailed;

  sc_button_conditioner_if btnBus ();

  assign btnBus.SC_BUTTONCOND_raw_InLow = rawDrv;
  assign levelObs = btnBus.SC_BUTTONCOND_level_OutLow;
  assign pressObs = btnBus.SC_BUTTONCOND_press_Out;

  sc_button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES  (10),
    .CNT_W          (24)
  ) dut (
    .SC_BUTTONCOND_CLOCK_50   (clk),
    .SC_BUTTONCOND_RESET_InLow(rstN),
    .btnIf                    (btnBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one clock edge, then sample 1 time unit later
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [4:0] expL, expP;
    rawDrv = 5'b00000;
    rstN   = 1'b0;
    tick;
    tick;
    testsRun++;
    if (levelObs !== 5'b11111) begin
      testsFailed++;
      $display("FAIL reset_level: got %b want %b", levelObs, 5'b11111);
    end
    testsRun++;
    if (pressObs !== 5'b00000) begin
      testsFailed++;
      $display("FAIL reset_press: got %b want %b", pressObs, 5'b00000);
    end
    rawDrv = 5'b11110;
    rstN   = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick;
      expL = (k >= 6) ? 5'b11110 : 5'b11111;
      expP = (k == 6) ? 5'b00001 : 5'b00000;
      testsRun++;
      if (levelObs !== expL || pressObs !== expP) begin
        testsFailed++;
        $display("FAIL held_after_reset edge %0d: level %b press %b want %b %b",
                 k, levelObs, pressObs, expL, expP);
      end
    end
    rawDrv = 5'b11111;
    repeat (8) tick;
    testsRun++;
    if (levelObs !== 5'b11111) begin
      testsFailed++;
      $display("FAIL reset_release: got %b want %b", levelObs, 5'b11111);
    end
  endtask

  task automatic test_bounce;
    logic lowNow;
    for (int k = 0; k < 14; k++) begin
      lowNow = (k < 3) || (k >= 4 && k < 7);
      rawDrv = {2'b11, ~lowNow, 2'b11};
      tick;
      testsRun++;
      if (levelObs !== 5'b11111 || pressObs !== 5'b00000) begin
        testsFailed++;
        $display("FAIL bounce step %0d: level %b press %b want 11111 00000",
                 k, levelObs, pressObs);
      end
    end
  endtask

  task automatic test_clean_press;
    logic expLvl, expPrs;
    rawDrv = 5'b11101;
    for (int k = 1; k <= 32; k++) begin
      tick;
      if (k == 20) rawDrv = 5'b11111;
`ifdef SC_BUTTONCOND_AUTOREPEAT_EN
      expLvl = !((k >= 6 && k <= 15) || (k >= 18 && k <= 25));
      expPrs = (k == 6) || (k == 18);
`else
      expLvl = !(k >= 6 && k <= 25);
      expPrs = (k == 6);
`endif
      testsRun++;
      if (levelObs !== {3'b111, expLvl, 1'b1} || pressObs !== {3'b000, expPrs, 1'b0}) begin
        testsFailed++;
        $display("FAIL clean_press edge %0d: level %b press %b want %b %b",
                 k, levelObs, pressObs, {3'b111, expLvl, 1'b1}, {3'b000, expPrs, 1'b0});
      end
    end
  endtask

  task automatic test_simultaneous;
    logic [4:0] expL, expP;
    rawDrv = 5'b10110;
    for (int k = 1; k <= 8; k++) begin
      tick;
      expL = (k >= 6) ? 5'b10110 : 5'b11111;
      expP = (k == 6) ? 5'b01001 : 5'b00000;
      testsRun++;
      if (levelObs !== expL || pressObs !== expP) begin
        testsFailed++;
        $display("FAIL simultaneous edge %0d: level %b press %b want %b %b",
                 k, levelObs, pressObs, expL, expP);
      end
    end
    rawDrv = 5'b11111;
    repeat (8) tick;
    testsRun++;
    if (levelObs !== 5'b11111) begin
      testsFailed++;
      $display("FAIL simultaneous_release: got %b want %b", levelObs, 5'b11111);
    end
  endtask

  task automatic test_reset_mid_count;
    logic [4:0] expL, expP;
    rawDrv = 5'b11110;
    repeat (8) tick;
    testsRun++;
    if (levelObs !== 5'b11110) begin
      testsFailed++;
      $display("FAIL midreset_pre: got %b want %b", levelObs, 5'b11110);
    end
    rawDrv = 5'b01110;
    repeat (5) tick;
    rstN = 1'b0;
    #2;
    testsRun++;
    if (levelObs !== 5'b11111 || pressObs !== 5'b00000) begin
      testsFailed++;
      $display("FAIL midreset_async: level %b press %b want 11111 00000", levelObs, pressObs);
    end
    tick;
    testsRun++;
    if (levelObs !== 5'b11111 || pressObs !== 5'b00000) begin
      testsFailed++;
      $display("FAIL midreset_hold: level %b press %b want 11111 00000", levelObs, pressObs);
    end
    rstN = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick;
      expL = (k >= 6) ? 5'b01110 : 5'b11111;
      expP = (k == 6) ? 5'b10001 : 5'b00000;
      testsRun++;
      if (levelObs !== expL || pressObs !== expP) begin
        testsFailed++;
        $display("FAIL midreset_restart edge %0d: level %b press %b want %b %b",
                 k, levelObs, pressObs, expL, expP);
      end
    end
    rawDrv = 5'b11111;
    repeat (8) tick;
    testsRun++;
    if (levelObs !== 5'b11111) begin
      testsFailed++;
      $display("FAIL midreset_release: got %b want %b", levelObs, 5'b11111);
    end
  endtask

`ifdef SC_BUTTONCOND_AUTOREPEAT_EN
  task automatic test_autorepeat;
    logic lvl0, prs0;
    logic [4:0] expL, expP;
    rawDrv = 5'b01110;
    for (int k = 1; k <= 40; k++) begin
      tick;
      lvl0 = (k < 6) || (k >= 16 && ((k - 16) % 12) < 2);
      prs0 = (k == 6) || (k >= 18 && ((k - 18) % 12) == 0);
      expL = {(k < 6), 3'b111, lvl0};
      expP = {(k == 6), 3'b000, prs0};
      testsRun++;
      if (levelObs !== expL || pressObs !== expP) begin
        testsFailed++;
        $display("FAIL autorepeat edge %0d: level %b press %b want %b %b",
                 k, levelObs, pressObs, expL, expP);
      end
    end
    rawDrv = 5'b11111;
    repeat (10) tick;
    testsRun++;
    if (levelObs !== 5'b11111) begin
      testsFailed++;
      $display("FAIL autorepeat_release: got %b want %b", levelObs, 5'b11111);
    end
  endtask
`endif

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rawDrv      = 5'b11111;
    rstN        = 1'b0;
    test_reset();
    test_bounce();
    test_clean_press();
    test_simultaneous();
    test_reset_mid_count();
`ifdef SC_BUTTONCOND_AUTOREPEAT_EN
    test_autorepeat();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
